// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit over a word-organised data memory (IDLE -> WAIT -> DONE).
// Define LSU_MISALIGN_TRAP_EN to suppress and flag misaligned halfword/word accesses.
module load_store_unit #(
  parameter int MEM_WORDS = 128,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int AW    = IDX_W + 2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          f3_q, f3_d;
  logic                store_q, store_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                mis_q, mis_d;

  logic                request;
  logic                commit;
  logic                wr_en;
  logic [IDX_W-1:0]    idx;
  logic [MEM_WORDS-1:0][31:0] mem_rd;
  logic [31:0]         word;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [31:0]         ld_data;
  logic [31:0]         st_data;
  logic [3:0]          st_be;
  logic                acc_mis;

  // Upper address bits only select aliases of the same word; they wrap silently.
  logic unused_addr;
  assign unused_addr = ^address[31:AW];

  assign request = memread | memwrite;
  assign commit  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign idx     = addr_q[AW-1:2];
  assign wr_en   = rst & commit & store_q;

  // Memory words start at their own index and are never touched by reset.
  for (genvar gi = 0; gi < MEM_WORDS; gi++) begin : g_word
    logic [31:0] word_q = 32'(gi);
    always_ff @(posedge clk) begin
      if (wr_en && idx == IDX_W'(gi)) begin
        for (int b = 0; b < 4; b++) begin
          if (st_be[b]) word_q[8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
    assign mem_rd[gi] = word_q;
  end

  always_comb begin
    acc_mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (store_q)
      acc_mis = (f3_q == 3'b001 && addr_q[0]) ||
                (f3_q == 3'b010 && addr_q[1:0] != 2'b00);
    else
      acc_mis = ((f3_q == 3'b001 || f3_q == 3'b101) && addr_q[0]) ||
                (f3_q == 3'b010 && addr_q[1:0] != 2'b00);
`endif
  end

  // Lane extraction: halfwords use only address[1], words ignore the offset.
  always_comb begin
    word   = mem_rd[idx];
    byte_v = word[{addr_q[1:0], 3'b000} +: 8];
    half_v = word[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_data = {{16{half_v[15]}}, half_v};
      3'b010:  ld_data = word;
      3'b100:  ld_data = {24'h0, byte_v};
      3'b101:  ld_data = {16'h0, half_v};
      default: ld_data = 32'h0;
    endcase
    if (acc_mis) ld_data = 32'h0;
  end

  always_comb begin
    st_data = wdata_q;
    case (f3_q)
      3'b000: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      3'b010:  st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
    if (acc_mis) st_be = 4'b0000;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    store_d    = store_q;
    readdata_d = readdata_q;
    mis_d      = mis_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          addr_d  = address[AW-1:0];
          wdata_d = writedata;
          f3_d    = funct3;
          store_d = memwrite;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          mis_d   = acc_mis;
          if (!store_q || acc_mis) readdata_d = ld_data;
        end
      end
      DONE: begin
        // A request still present here belongs to the instruction just finished.
        state_d = IDLE;
        mis_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      f3_q       <= 3'b000;
      store_q    <= 1'b0;
      readdata_q <= 32'h0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      store_q    <= store_d;
      readdata_q <= readdata_d;
      mis_q      <= mis_d;
    end
  end

  assign stall      = rst & (((state_q == IDLE) & request) | (state_q == WAIT));
  assign readdata   = readdata_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (MEM_WORDS=128, LATENCY=2).
module tb_load_store_unit;

  localparam int LAT = 2;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        stall;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(128), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .address(address), .writedata(writedata),
    .readdata(readdata), .stall(stall), .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one request and checks stall length,
  // DONE-cycle readdata/misaligned, and that both settle afterwards.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input bit scramble);
    int n;
    n = 0;
    memread = rd; memwrite = wr; funct3 = f3; address = a; writedata = wd;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!stall) break;
      n++;
      if (scramble && n == 2) begin
        address = ~a; writedata = ~wd; funct3 = 3'b010;
      end
      @(negedge clk);
    end
    chk({tag, " stall_cycles"}, 32'(n), 32'(LAT + 1));
    chk({tag, " readdata"}, readdata, exp_rd);
    chk({tag, " misaligned"}, {31'h0, misaligned}, {31'h0, exp_mis});
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk); #1;
    chk({tag, " mis_clear"}, {31'h0, misaligned}, 32'h0);
    chk({tag, " rd_hold"}, readdata, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    memread = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset readdata", readdata, 32'h0);
    chk("reset misaligned", {31'h0, misaligned}, 32'h0);
    memread = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    access("lw10",   1, 0, 3'b010, 32'h10, 32'h0, 32'h00000004, 0, 0);
    access("sw20",   0, 1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h00000004, 0, 0);
    access("lw20",   1, 0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 0, 0);
    access("sb21",   0, 1, 3'b000, 32'h21, 32'h80, 32'hDEADBEEF, 0, 0);
    access("lb21",   1, 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0, 0);
    access("lbu21",  1, 0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0, 0);
    access("lw20b",  1, 0, 3'b010, 32'h20, 32'h0, 32'hDEAD80EF, 0, 0);
    access("lh22",   1, 0, 3'b001, 32'h22, 32'h0, 32'hFFFFDEAD, 0, 0);
    access("lhu22",  1, 0, 3'b101, 32'h22, 32'h0, 32'h0000DEAD, 0, 0);
    access("sh26",   0, 1, 3'b001, 32'h26, 32'h1234ABCD, 32'h0000DEAD, 0, 0);
    access("lw24",   1, 0, 3'b010, 32'h24, 32'h0, 32'hABCD0009, 0, 0);

    access("lw202",  1, 0, 3'b010, 32'h202, 32'h0, 32'h00000000, TRAP, 0);
    access("lh23",   1, 0, 3'b001, 32'h23, 32'h0, TRAP ? 32'h0 : 32'hFFFFDEAD, TRAP, 0);
    access("sw25",   0, 1, 3'b010, 32'h25, 32'h0, TRAP ? 32'h0 : 32'hFFFFDEAD, TRAP, 0);
    access("lw24b",  1, 0, 3'b010, 32'h24, 32'h0, TRAP ? 32'hABCD0009 : 32'h0, 0, 0);

    access("ld_bad", 1, 0, 3'b011, 32'h20, 32'h0, 32'h00000000, 0, 0);
    access("st_bad", 0, 1, 3'b011, 32'h24, 32'hFFFFFFFF, 32'h00000000, 0, 0);
    access("lw24c",  1, 0, 3'b010, 32'h24, 32'h0, TRAP ? 32'hABCD0009 : 32'h0, 0, 0);

    access("lw14_scr", 1, 0, 3'b010, 32'h14, 32'h0, 32'h00000005, 0, 1);
    access("sw204",  0, 1, 3'b010, 32'h204, 32'h11, 32'h00000005, 0, 0);
    access("lw04",   1, 0, 3'b010, 32'h04, 32'h0, 32'h00000011, 0, 0);

    // Reset asserted in the commit cycle of a store: no write must happen.
    memwrite = 1'b1; funct3 = 3'b010; address = 32'h30; writedata = 32'h55;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; memwrite = 1'b0;
    @(negedge clk); #1;
    chk("rst_wait stall", {31'h0, stall}, 32'h0);
    chk("rst_wait readdata", readdata, 32'h0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_rel stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    access("lw30",   1, 0, 3'b010, 32'h30, 32'h0, 32'h0000000C, 0, 0);

    access("both40", 1, 1, 3'b010, 32'h40, 32'h7, 32'h0000000C, 0, 0);
    access("lw40",   1, 0, 3'b010, 32'h40, 32'h0, 32'h00000007, 0, 0);
    access("sb43",   0, 1, 3'b000, 32'h43, 32'hAB, 32'h00000007, 0, 0);
    access("lb43",   1, 0, 3'b000, 32'h43, 32'h0, 32'hFFFFFFAB, 0, 0);
    access("lw40b",  1, 0, 3'b010, 32'h40, 32'h0, 32'hAB000007, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 128: number of 32-bit data words, a power of two from 16 to 4096.
REQ-002 SHALL have parameter LATENCY, default 2: access wait cycles, range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port memread, input, 1 bit: load request from execute stage.
REQ-006 SHALL have port memwrite, input, 1 bit: store request from execute stage.
REQ-007 SHALL have port funct3, input, 3 bits: access size and sign (RV32I encoding).
REQ-008 SHALL have port address, input, 32 bits: byte address (ALU result).
REQ-009 SHALL have port writedata, input, 32 bits: store data (rs2 value).
REQ-010 SHALL have port readdata, output, 32 bits: registered load result to writeback.
REQ-011 SHALL have port stall, output, 1 bit: holds the core's PC and pipeline inputs while high.
REQ-012 SHALL have port misaligned, output, 1 bit: misaligned-access flag.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, DONE; request = memread | memwrite.
REQ-014 In IDLE with request: capture address, writedata, funct3 and op; load counter with LATENCY-1; go to WAIT.
REQ-015 In WAIT with counter != 0: decrement the counter. With counter == 0: perform the access and go to DONE.
REQ-016 DONE SHALL last exactly one cycle, then go to IDLE. A request in DONE SHALL be ignored; it is the same instruction.
REQ-017 stall = (IDLE & request) | WAIT, combinational. Each access therefore stalls for LATENCY+1 cycles, followed by one unstalled DONE cycle.
REQ-018 When memread and memwrite are both high, the access SHALL be treated as a store.
REQ-019 Word index = address[31:2] modulo MEM_WORDS; out-of-range addresses SHALL wrap silently.
REQ-020 Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. lb/lh sign-extend; lbu/lhu zero-extend. Lanes are selected by address[1:0], little-endian.
REQ-021 Stores: 000 sb, 001 sh, 010 sw. Only the addressed byte lanes SHALL be written.
REQ-022 Any other funct3 SHALL complete normally with no write; a load returns 0.
REQ-023 readdata SHALL update only on load completion and hold its value otherwise.
REQ-024 Captured inputs SHALL be used for the access; input changes during WAIT SHALL be ignored.
REQ-025 Memory word i SHALL initialise to i at time zero and SHALL NOT be cleared by rst.

Reset
REQ-026 rst low SHALL force state IDLE, counter 0, readdata 0, stall 0, misaligned 0.
REQ-027 Reset during WAIT SHALL abandon the access with no memory write. Reset in the commit cycle SHALL take priority over the write.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-029 With LSU_MISALIGN_TRAP_EN defined:
- lh/lhu/sh with address[0]=1, or lw/sw with address[1:0]!=0, SHALL perform no write.
- readdata SHALL be set to 0.
- misaligned SHALL pulse high for exactly the DONE cycle.
- Timing is identical to an aligned access.
REQ-030 Without LSU_MISALIGN_TRAP_EN:
- Halfword accesses ignore address[0]; word accesses ignore address[1:0].
- misaligned SHALL be tied to 0.

Verification
REQ-031 After reset, lw with address=0x10 (LATENCY=2) -> stall high 3 cycles, then DONE with readdata=0x00000004, stall=0.
REQ-032 sw with address=0x20, writedata=0xDEADBEEF, then lw 0x20 -> readdata=0xDEADBEEF.
REQ-033 sb with address=0x21, writedata=0x80; then lb 0x21 -> 0xFFFFFF80, lbu 0x21 -> 0x00000080, lw 0x20 -> 0xDEAD80EF.
REQ-034 lw with address=0x202 (MEM_WORDS=128) -> word 0 accessed. With LSU_MISALIGN_TRAP_EN, misaligned=1 for one cycle and readdata=0; without it, readdata=0x00000000.
REQ-035 sw with address=0x30, writedata=0x55, rst low during WAIT -> stall=0 next cycle, then lw 0x30 -> readdata=0x0000000C.
REQ-036 memread=memwrite=1 with address=0x40, writedata=7 -> store performed, readdata unchanged; then lw 0x40 -> 0x00000007.
